// File: rtl/sensor_debounce_hub.sv
// Sensor/button conditioning: 2-flop sync, polarity fix, counter debounce, and a
// FIFO of debounced rising-edge channel indices with a valid/ready handshake.
module sensor_debounce_hub #(
  parameter int unsigned          CHANNELS        = 24,
  parameter int unsigned          IDX_W           = 5,
  parameter int unsigned          DEBOUNCE_CYCLES = 50000,
  parameter int unsigned          CNT_W           = 16,
  parameter logic [CHANNELS-1:0]  INVERT_MASK     = '0,
  parameter int unsigned          EVT_DEPTH       = 8,
  parameter int unsigned          LVL_W           = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] stable_out,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_index,
  output logic [LVL_W-1:0]    evt_level,
  output logic [7:0]          drop_count,
  input  logic                clear_drops
);

  localparam int unsigned      PtrW    = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LVL_W-1:0] LvlFull = LVL_W'(EVT_DEPTH);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(EVT_DEPTH - 1);

  logic [CHANNELS-1:0] sync1_q, sync2_q, cond;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] stable_q, stable_d, rise_q;
  logic [CHANNELS-1:0] pending_q, pending_d, push_mask, merge;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_valid;
  logic [IDX_W-1:0]    mem_q [EVT_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic [7:0]          drop_q, drop_d;
  logic                full, pop, push;

  assign cond = sync2_q ^ INVERT_MASK;

  // Counter runs only while cond disagrees; any agreement restarts the window.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cnt_d[i]    = '0;
      stable_d[i] = stable_q[i];
      if (cond[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Lowest-index pending channel wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign full      = (level_q == LvlFull);
  assign evt_valid = (level_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign push      = sel_valid & (~full | pop);
  assign push_mask = push ? (CHANNELS'(1) << sel_idx) : '0;
  assign merge     = rise_q & pending_q & ~push_mask;
  assign pending_d = (pending_q & ~push_mask) | rise_q;

  always_comb begin
    int unsigned sum;
    sum = 32'(drop_q);
    for (int i = 0; i < int'(CHANNELS); i++) begin
      sum = sum + 32'(merge[i]);
    end
    if (clear_drops) begin
      drop_d = '0;
    end else if (sum > 32'd255) begin
      drop_d = 8'hff;
    end else begin
      drop_d = 8'(sum);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '{default: '0};
      stable_q  <= '0;
      rise_q    <= '0;
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      drop_q    <= '0;
    end else begin
      sync1_q   <= raw_in;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      rise_q    <= stable_d & ~stable_q;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (resetn && push) begin
      mem_q[wr_ptr_q] <= sel_idx;
    end
  end

  assign stable_out = stable_q;
  assign evt_index  = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign evt_level  = level_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_sensor_debounce_hub.sv
// Bench for sensor_debounce_hub: directed scenarios plus random stimulus, every cycle
// compared against a queue-based behavioural model.
module tb_sensor_debounce_hub;

  localparam int unsigned CH    = 8;
  localparam int unsigned DB    = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  INV   = 8'h80;

  logic       clock = 1'b0;
  logic       resetn, evt_ready, clear_drops, evt_valid;
  logic [7:0] raw_in, stable_out, drop_count;
  logic [2:0] evt_index, evt_level;

  always #5 clock = ~clock;

  sensor_debounce_hub #(
    .CHANNELS(CH), .IDX_W(3), .DEBOUNCE_CYCLES(DB), .CNT_W(4),
    .INVERT_MASK(INV), .EVT_DEPTH(DEPTH), .LVL_W(3)
  ) dut (
    .clock(clock), .resetn(resetn), .raw_in(raw_in), .stable_out(stable_out),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
    .evt_level(evt_level), .drop_count(drop_count), .clear_drops(clear_drops)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: raw sample history, per-channel disagreement run length,
  // set of pending channels and a queue of queued event indices.
  logic [7:0] hist[$];
  logic [7:0] m_stable = '0;
  logic [7:0] m_rise   = '0;
  logic [7:0] m_pend   = '0;
  int         m_run[CH];
  int         m_drop   = 0;
  int         mq[$];

  task automatic model_step(input logic [7:0] r, input logic rdy, input logic clr,
                            input logic rstn);
    logic [7:0] cond, pushed, merged, new_stable;
    bit         pop_now, can_push;
    int         idx;
    if (!rstn) begin
      hist.delete();
      mq.delete();
      m_stable = '0;
      m_rise   = '0;
      m_pend   = '0;
      m_drop   = 0;
      foreach (m_run[i]) m_run[i] = 0;
      return;
    end
    // Debounce sees the raw value sampled two edges earlier.
    hist.push_back(r);
    if (hist.size() > 3) void'(hist.pop_front());
    cond = ((hist.size() == 3) ? hist[0] : 8'h00) ^ INV;

    pop_now  = (mq.size() != 0) && rdy;
    can_push = (mq.size() < DEPTH) || pop_now;
    pushed   = '0;
    idx      = -1;
    for (int i = 0; i < CH; i++) begin
      if (idx < 0 && m_pend[i]) idx = i;
    end
    if (pop_now) void'(mq.pop_front());
    if (idx >= 0 && can_push) begin
      mq.push_back(idx);
      pushed[idx] = 1'b1;
    end
    merged = m_rise & m_pend & ~pushed;
    m_pend = (m_pend & ~pushed) | m_rise;
    if (clr) m_drop = 0;
    else     m_drop = (m_drop + $countones(merged) > 255) ? 255 : m_drop + $countones(merged);

    new_stable = m_stable;
    for (int i = 0; i < CH; i++) begin
      m_run[i] = (cond[i] != m_stable[i]) ? m_run[i] + 1 : 0;
      if (m_run[i] == DB) begin
        new_stable[i] = ~m_stable[i];
        m_run[i]      = 0;
      end
    end
    m_rise   = new_stable & ~m_stable;
    m_stable = new_stable;
  endtask

  task automatic compare_all();
    check_eq("stable", 32'(stable_out), 32'(m_stable));
    check_eq("valid", 32'(evt_valid), 32'(mq.size() != 0));
    check_eq("index", 32'(evt_index), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check_eq("level", 32'(evt_level), 32'(mq.size()));
    check_eq("drops", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic step(input logic [7:0] r, input logic rdy, input logic clr, input logic rstn);
    raw_in      = r;
    evt_ready   = rdy;
    clear_drops = clr;
    resetn      = rstn;
    @(posedge clock);
    model_step(r, rdy, clr, rstn);
    #1;
    compare_all();
  endtask

  task automatic run(input logic [7:0] r, input logic rdy, input logic clr, input int n);
    for (int k = 0; k < n; k++) step(r, rdy, clr, 1'b1);
  endtask

  initial begin
    logic [7:0] cur;
    foreach (m_run[i]) m_run[i] = 0;
    raw_in = 8'h80; evt_ready = 1'b0; clear_drops = 1'b0; resetn = 1'b0;

    // 1: reset, idle inverted channel, then reset with events queued
    step(8'h80, 1'b0, 1'b0, 1'b0);
    step(8'h80, 1'b0, 1'b0, 1'b0);
    run(8'h80, 1'b0, 1'b0, 20);
    check_eq("s1_idle_stable", 32'(stable_out), 32'h00);
    check_eq("s1_idle_valid", 32'(evt_valid), 32'd0);
    run(8'h83, 1'b0, 1'b0, 12);
    check_eq("s1_pre_level", 32'(evt_level), 32'd2);
    step(8'h80, 1'b0, 1'b0, 1'b0);
    check_eq("s1_rst_stable", 32'(stable_out), 32'h00);
    check_eq("s1_rst_level", 32'(evt_level), 32'd0);
    check_eq("s1_rst_index", 32'(evt_index), 32'd0);
    run(8'h80, 1'b0, 1'b0, 12);

    // 2: latency of a clean rise on channel 2
    run(8'h84, 1'b0, 1'b0, 5);
    check_eq("s2_pre_stable", 32'(stable_out), 32'h00);
    run(8'h84, 1'b0, 1'b0, 1);
    check_eq("s2_lat_stable", 32'(stable_out), 32'h04);
    run(8'h84, 1'b0, 1'b0, 1);
    check_eq("s2_valid_e7", 32'(evt_valid), 32'd0);
    run(8'h84, 1'b0, 1'b0, 1);
    check_eq("s2_valid_e8", 32'(evt_valid), 32'd1);
    check_eq("s2_index", 32'(evt_index), 32'd2);
    check_eq("s2_level", 32'(evt_level), 32'd1);
    run(8'h84, 1'b1, 1'b0, 1);
    run(8'h80, 1'b0, 1'b0, 12);
    check_eq("s2_fall_noevt", 32'(evt_valid), 32'd0);

    // 3: glitch rejection, then a pulse just long enough
    run(8'h88, 1'b0, 1'b0, 3);
    run(8'h80, 1'b0, 1'b0, 12);
    check_eq("s3_glitch_valid", 32'(evt_valid), 32'd0);
    run(8'h88, 1'b0, 1'b0, 6);
    run(8'h80, 1'b0, 1'b0, 12);
    check_eq("s3_pulse_level", 32'(evt_level), 32'd1);
    check_eq("s3_pulse_index", 32'(evt_index), 32'd3);
    run(8'h80, 1'b1, 1'b0, 1);
    run(8'h80, 1'b0, 1'b0, 12);
    check_eq("s3_one_event", 32'(evt_level), 32'd0);

    // 4: simultaneous rises drain lowest index first
    run(8'he2, 1'b0, 1'b0, 12);
    check_eq("s4_peak", 32'(evt_level), 32'd3);
    check_eq("s4_first", 32'(evt_index), 32'd1);
    run(8'he2, 1'b1, 1'b0, 1);
    check_eq("s4_second", 32'(evt_index), 32'd5);
    run(8'he2, 1'b1, 1'b0, 1);
    check_eq("s4_third", 32'(evt_index), 32'd6);
    run(8'he2, 1'b1, 1'b0, 1);
    check_eq("s4_empty", 32'(evt_level), 32'd0);
    run(8'h80, 1'b0, 1'b0, 12);

    // 5/6: full FIFO holds channel 4 pending; second rise merges
    run(8'h8f, 1'b0, 1'b0, 12);
    check_eq("s5_full", 32'(evt_level), 32'd4);
    run(8'h9f, 1'b0, 1'b0, 8);
    run(8'h8f, 1'b0, 1'b0, 8);
    run(8'h9f, 1'b0, 1'b0, 8);
    check_eq("s5_drop", 32'(drop_count), 32'd1);
    run(8'h9f, 1'b1, 1'b0, 1);
    check_eq("s6_level_kept", 32'(evt_level), 32'd4);
    run(8'h9f, 1'b1, 1'b0, 3);
    check_eq("s5_tail_index", 32'(evt_index), 32'd4);
    run(8'h80, 1'b1, 1'b0, 12);
    run(8'h8f, 1'b0, 1'b0, 12);
    run(8'h9f, 1'b0, 1'b0, 8);
    run(8'h8f, 1'b0, 1'b0, 8);
    run(8'h9f, 1'b0, 1'b1, 8);
    check_eq("s6_clear_wins", 32'(drop_count), 32'd0);
    run(8'h80, 1'b1, 1'b0, 16);

    // Random phase
    cur = 8'h80;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < CH; b++) begin
        if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      end
      step(cur, ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 399) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
